// File: rtl/lenet_pkg.sv
// lenet_pkg: shared types, dimensions and helpers for the LeNet line controllers.
package lenet_pkg;

  localparam int DATA_W = 8;
  localparam int FM_IN  = 28;
  localparam int FM_OUT = 14;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    EVEN_ROW = 4'd1,
    ODD_ROW  = 4'd2,
    FINISH   = 4'd4
  } state_e;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/out_line_controller_if.sv
// out_line_controller_if: conv result stream in, pooled stream out.
interface out_line_controller_if #(
  parameter int DATA_W = lenet_pkg::DATA_W
);

  logic                     i_conv_valid;
  logic                     o_conv_ready;
  logic                     i_conv_row_start;
  logic                     i_conv_row_end;
  logic signed [DATA_W-1:0] i_conv_data;
  logic                     o_pool_valid;
  logic                     i_pool_ready;
  logic signed [DATA_W-1:0] o_pool_data;
  logic                     o_pool_row_end;

  modport master (
    output i_conv_valid, i_conv_row_start,
    output i_conv_row_end, i_conv_data,
    output i_pool_ready,
    input  o_conv_ready, o_pool_valid,
    input  o_pool_data, o_pool_row_end
  );

  modport slave (
    input  i_conv_valid, i_conv_row_start,
    input  i_conv_row_end, i_conv_data,
    input  i_pool_ready,
    output o_conv_ready, o_pool_valid,
    output o_pool_data, o_pool_row_end
  );

endinterface

// File: rtl/pool_line_buf.sv
// pool_line_buf: half-width line of pair maxima, one write and one registered read.
module pool_line_buf #(
  parameter int DEPTH  = 14,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/out_line_controller.sv
// out_line_controller: 2x2 stride-2 max pooling of the conv result stream.
// Define OUT_LINE_RELU_EN to clamp every accepted sample at zero first.
module out_line_controller #(
  parameter int IN_W   = 28,
  parameter int IN_H   = 28,
  parameter int DATA_W = lenet_pkg::DATA_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  output logic        o_done,
  out_line_controller_if.slave bus,
  output logic        o_err,
  output logic [3:0]  o_current_state,
  output logic [4:0]  o_in_col,
  output logic [4:0]  o_in_row
);

  import lenet_pkg::*;

  localparam int AW = $clog2(IN_W / 2);
  localparam logic [4:0] COL_LAST = 5'(IN_W - 1);
  localparam logic [4:0] ROW_LAST = 5'(IN_H - 1);

  typedef logic signed [DATA_W-1:0] smp_t;

  state_e     state_q, state_d;
  logic [4:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  smp_t       pair_q, pair_d;
  smp_t       pool_q, pool_d;
  logic       pv_q, pv_d;
  logic       pre_q, pre_d;
  logic       err_q, err_d;
  logic       done_q, done_d;

  smp_t x, pmax, lb_rdata;
  logic accept, col_last, lb_we, load;

  always_comb begin
`ifdef OUT_LINE_RELU_EN
    x = smax(bus.i_conv_data, '0);
`else
    x = bus.i_conv_data;
`endif
  end

  assign bus.o_conv_ready =
    (state_q == EVEN_ROW) ||
    (state_q == ODD_ROW && (!pv_q || bus.i_pool_ready));

  assign accept   = bus.i_conv_valid && bus.o_conv_ready;
  assign col_last = (col_q == COL_LAST);
  assign pmax     = smax(pair_q, x);
  assign lb_we    = accept && state_q == EVEN_ROW && col_q[0];
  assign load     = accept && state_q == ODD_ROW && col_q[0];

  // Read address follows the column counter, so the entry is
  // already registered by the time the odd column arrives.
  pool_line_buf #(
    .DEPTH  (IN_W / 2),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (col_q[AW:1]),
    .wdata (pmax),
    .raddr (col_q[AW:1]),
    .rdata (lb_rdata)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    pool_d  = pool_q;
    pv_d    = pv_q;
    pre_d   = pre_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (pv_q && bus.i_pool_ready) begin
      pv_d   = 1'b0;
      pool_d = '0;
      pre_d  = 1'b0;
    end
    if (load) begin
      pv_d   = 1'b1;
      pool_d = smax(lb_rdata, pmax);
      pre_d  = col_last;
    end
    if (accept) begin
      if (!col_q[0]) pair_d = x;
      if (bus.i_conv_row_start != (col_q == 5'd0) ||
          bus.i_conv_row_end != col_last)
        err_d = 1'b1;
      col_d = col_last ? 5'd0 : col_q + 5'd1;
      if (col_last)
        row_d = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    end
    unique case (state_q)
      IDLE: if (i_start) begin
        state_d = EVEN_ROW;
        col_d   = '0;
        row_d   = '0;
      end
      EVEN_ROW: if (accept && col_last) state_d = ODD_ROW;
      ODD_ROW: if (accept && col_last)
        state_d = (row_q == ROW_LAST) ? FINISH : EVEN_ROW;
      FINISH: if (!pv_q || bus.i_pool_ready) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      pool_q  <= '0;
      pv_q    <= 1'b0;
      pre_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      pool_q  <= pool_d;
      pv_q    <= pv_d;
      pre_q   <= pre_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_pool_valid   = pv_q;
  assign bus.o_pool_data    = pool_q;
  assign bus.o_pool_row_end = pre_q;
  assign o_done             = done_q;
  assign o_err              = err_q;
  assign o_current_state    = state_q;
  assign o_in_col           = col_q;
  assign o_in_row           = row_q;

endmodule

// File: tb/tb_out_line_controller.sv
// tb_out_line_controller: directed frames against a 2x2 max-pool reference.
module tb_out_line_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic       o_done;
  logic       o_err;
  logic [3:0] st;
  logic [4:0] icol;
  logic [4:0] irow;

  out_line_controller_if #(.DATA_W(8)) bus();

  out_line_controller #(
    .IN_W   (28),
    .IN_H   (28),
    .DATA_W (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .o_done          (o_done),
    .bus             (bus),
    .o_err           (o_err),
    .o_current_state (st),
    .o_in_col        (icol),
    .o_in_row        (irow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic signed [7:0] got [196];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [7:0] in_val(input int kind,
                                               input int r,
                                               input int c);
    if (kind == 0) return 8'((r * 28 + c) % 128);
    return -8'sd5;
  endfunction

  function automatic logic signed [7:0] exp_pool(input int kind,
                                                 input int pr,
                                                 input int pc);
    logic signed [7:0] m;
    logic signed [7:0] v;
    m = in_val(kind, 2 * pr, 2 * pc);
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = in_val(kind, 2 * pr + dr, 2 * pc + dc);
        if (v > m) m = v;
      end
`ifdef OUT_LINE_RELU_EN
    if (m < 8'sd0) m = 8'sd0;
`endif
    return m;
  endfunction

  task automatic idle_inputs();
    i_start              = 1'b0;
    bus.i_conv_valid     = 1'b0;
    bus.i_conv_row_start = 1'b0;
    bus.i_conv_row_end   = 1'b0;
    bus.i_conv_data      = '0;
    bus.i_pool_ready     = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 32'(st), 32'(0));
    chk({tag, "_col"}, 32'(icol), 32'(0));
    chk({tag, "_row"}, 32'(irow), 32'(0));
    chk({tag, "_pvalid"}, 32'(bus.o_pool_valid), 32'(0));
    chk({tag, "_pdata"}, 32'(bus.o_pool_data), 32'(0));
    chk({tag, "_prowend"}, 32'(bus.o_pool_row_end), 32'(0));
    chk({tag, "_cready"}, 32'(bus.o_conv_ready), 32'(0));
    chk({tag, "_done"}, 32'(o_done), 32'(0));
    chk({tag, "_err"}, 32'(o_err), 32'(0));
  endtask

  task automatic run_frame(input int kind, input int rdy_mode,
                           input int err_idx, input int start_idx,
                           input int abort_at, input logic exp_err);
    int idx = 0;
    int nout = 0;
    int ndone = 0;
    int cyc = 0;
    int last_hs = -10;
    int post = 0;
    int r, c;
    bit acc, hs;
    bit started = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (cyc < 6000 && post < 5) begin
      r = idx / 28;
      c = idx % 28;
      bus.i_conv_valid     = (idx < 784);
      bus.i_conv_data      = in_val(kind, r, c);
      bus.i_conv_row_start = (c == 0);
      bus.i_conv_row_end   = (c == 27) || (idx == err_idx);
      bus.i_pool_ready     = (rdy_mode == 0) || (cyc % 3 == 0);
      i_start = (idx == start_idx) && !started;
      if (i_start) started = 1'b1;
      #1;
      acc = bus.i_conv_valid && bus.o_conv_ready;
      hs  = bus.o_pool_valid && bus.i_pool_ready;
      if (o_done) begin
        ndone++;
        chk("done_outputs", 32'(nout), 32'(196));
        if (ndone == 1) chk("done_latency", 32'(cyc), 32'(last_hs + 1));
      end
      if (st == 4'd2 && bus.o_pool_valid && !bus.i_pool_ready)
        chk("bp_conv_ready", 32'(bus.o_conv_ready), 32'(0));
      if (hs) begin
        if (nout < 196) begin
          chk("pool_data", 32'(bus.o_pool_data),
              32'(exp_pool(kind, nout / 14, nout % 14)));
          chk("pool_row_end", 32'(bus.o_pool_row_end),
              32'(nout % 14 == 13));
          got[nout] = bus.o_pool_data;
        end
        nout++;
        last_hs = cyc;
      end
      if (acc && idx == err_idx) chk("err_before", 32'(o_err), 32'(0));
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx - 1 == err_idx) chk("err_after", 32'(o_err), 32'(1));
      end
      if (abort_at >= 0 && idx >= abort_at) break;
      if (ndone > 0) post++;
      @(negedge clk);
      cyc++;
    end
    if (abort_at < 0) begin
      chk("frame_outputs", 32'(nout), 32'(196));
      chk("frame_done_once", 32'(ndone), 32'(1));
      chk("frame_accepts", 32'(idx), 32'(784));
      chk("frame_err", 32'(o_err), 32'(exp_err));
      chk("frame_idle", 32'(st), 32'(0));
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Valid in IDLE must not be taken.
    bus.i_conv_valid = 1'b1;
    #1;
    chk("idle_ready", 32'(bus.o_conv_ready), 32'(0));
    @(negedge clk);
    chk("idle_col", 32'(icol), 32'(0));
    idle_inputs();

    run_frame(0, 0, -1, -1, -1, 1'b0);
    chk("ramp_out00", 32'(got[0]), 32'(29));
    chk("ramp_out01", 32'(got[1]), 32'(31));

    run_frame(0, 1, -1, -1, -1, 1'b0);
    chk("bp_out00", 32'(got[0]), 32'(29));

    run_frame(1, 0, -1, -1, -1, 1'b0);
`ifdef OUT_LINE_RELU_EN
    chk("neg_out", 32'(got[100]), 32'(0));
`else
    chk("neg_out", 32'(got[100]), 32'(-5));
`endif

    run_frame(0, 0, -1, 5, -1, 1'b0);

    run_frame(0, 0, 94, -1, -1, 1'b1);
    @(negedge clk);
    chk("err_sticky", 32'(o_err), 32'(1));

    run_frame(0, 1, -1, -1, 300, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;

    run_frame(0, 0, -1, -1, -1, 1'b0);
    chk("after_reset_out01", 32'(got[1]), 32'(31));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
